// File: rtl/seg_pkg.sv
// Shared types and constants for the BCD counter / multiplexed seven-segment display path.
package seg_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 8;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low segments, bit7 = dp (kept off)
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
    localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
    localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
    localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
    localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h90;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment code; non-BCD input blanks.
module seg7_decode
    import seg_pkg::*;
(
    input  bcd_t             digit,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Cascaded BCD counter with tick divider and blank-then-show multiplexed 7-seg scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                        clk,
    input  logic                        rst_syn,
    input  logic                        run,
    input  logic                        clr,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
    output logic [BCD_W*NUM_DIGITS-1:0] count_out,
    output logic                        carry_out,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       dig_sel
);

    localparam int unsigned CNT_W  = BCD_W * NUM_DIGITS;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  load_sane;
    logic              all_nines;
    logic              inc_carry;
    bcd_t              inc_digit;
    bcd_t              load_nib;

    scan_state_t       state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [SCAN_W-1:0] scan_cnt, scan_nx;
    logic [NUM_DIGITS-1:0] dig_sel_nx;
    logic [SEG_W-1:0]  seg_nx;
    logic [SEG_W-1:0]  dec_seg_c;
    bcd_t              show_digit;

    assign tick_c = run && (tick_cnt == TICK_W'(TICK_DIV - 1));

    // Decimal ripple increment and load sanitising (nibbles above 9 load as 0)
    always_comb begin
        count_inc = count_out;
        inc_carry = 1'b1;
        all_nines = 1'b1;
        inc_digit = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            inc_digit = count_out[BCD_W*i +: BCD_W];
            if (inc_digit != 4'd9) all_nines = 1'b0;
            if (inc_carry) begin
                if (inc_digit == 4'd9) begin
                    count_inc[BCD_W*i +: BCD_W] = '0;
                end else begin
                    count_inc[BCD_W*i +: BCD_W] = inc_digit + 4'd1;
                    inc_carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_sane = '0;
        load_nib  = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            load_nib = load_val[BCD_W*i +: BCD_W];
            load_sane[BCD_W*i +: BCD_W] = (load_nib > 4'd9) ? 4'd0 : load_nib;
        end
    end

    // Tick divider and count register: clr > load > tick
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            tick_cnt  <= '0;
            count_out <= '0;
            carry_out <= 1'b0;
        end else begin
            if (clr)
                tick_cnt <= '0;
            else if (run)
                tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);

            carry_out <= 1'b0;
            if (clr) begin
                count_out <= '0;
            end else if (load) begin
                count_out <= load_sane;
            end else if (tick_c) begin
                count_out <= count_inc;
                carry_out <= all_nines;
            end
        end
    end

    // Scan FSM state register; outputs are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            state    <= BLANK;
            idx      <= '0;
            scan_cnt <= '0;
            dig_sel  <= '1;
            seg_out  <= SEG_BLANK;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            scan_cnt <= scan_nx;
            dig_sel  <= dig_sel_nx;
            seg_out  <= seg_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        scan_nx  = scan_cnt;
        case (state)
            BLANK: begin
                state_nx = SHOW;
                scan_nx  = '0;
            end
            SHOW: begin
                if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                    state_nx = BLANK;
                    idx_nx   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                end else begin
                    scan_nx = scan_cnt + SCAN_W'(1);
                end
            end
            default: state_nx = BLANK;
        endcase
    end

    assign show_digit = count_out[BCD_W*idx_nx +: BCD_W];

    seg7_decode u_dec (
        .digit (show_digit),
        .seg_c (dec_seg_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] hi_zero;
    logic                  zero_run;

    // hi_zero[i]: digit i and every digit above it are zero
    always_comb begin
        hi_zero  = '0;
        zero_run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (count_out[BCD_W*i +: BCD_W] != 4'd0) zero_run = 1'b0;
            hi_zero[i] = zero_run;
        end
    end
`endif

    always_comb begin
        dig_sel_nx = '1;
        seg_nx     = SEG_BLANK;
        if (state_nx == SHOW) begin
            dig_sel_nx[idx_nx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            seg_nx = (idx_nx != '0 && hi_zero[idx_nx]) ? SEG_BLANK : dec_seg_c;
`else
            seg_nx = dec_seg_c;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl: directed vector table, scan sequences and randomized model comparison.
module tb_bcd_scan_ctrl;

    localparam int ND    = 4;
    localparam int TDIV  = 4;
    localparam int SDIV  = 3;
    localparam int MODV  = 10000;

    logic          clk = 1'b0;
    logic          rst_syn = 1'b0;
    logic          run = 1'b0;
    logic          clr = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   load_val = '0;
    logic [15:0]   count_out;
    logic          carry_out;
    logic [7:0]    seg_out;
    logic [3:0]    dig_sel;

    int checks = 0;
    int errors = 0;
    int carry_seen = 0;

    // Reference model state: count as a plain integer, scan as elapsed clocks since reset
    int m_cnt, m_tc, m_carry, m_p;
    logic [7:0] m_seg;
    logic [3:0] m_dig;

    bcd_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TDIV), .SCAN_DIV(SDIV)) dut (
        .clk       (clk),
        .rst_syn   (rst_syn),
        .run       (run),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .count_out (count_out),
        .carry_out (carry_out),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] ref_seg(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_tc = 0; m_carry = 0; m_p = 0;
        m_seg = 8'hFF; m_dig = 4'hF;
    endtask

    task automatic model_edge(input logic r, input logic c, input logic l, input logic [15:0] lv);
        int  prev, slot, phase, nib, d;
        logic tk;
        prev = m_cnt;
        tk   = r && (m_tc == TDIV - 1);
        if (c)      m_tc = 0;
        else if (r) m_tc = (m_tc + 1) % TDIV;
        m_carry = 0;
        if (c) begin
            m_cnt = 0;
        end else if (l) begin
            m_cnt = 0;
            for (int i = 0; i < ND; i++) begin
                nib = int'(lv[4*i +: 4]);
                if (nib > 9) nib = 0;
                m_cnt += nib * pow10(i);
            end
        end else if (tk) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == MODV) begin
                m_cnt   = 0;
                m_carry = 1;
            end
        end
        m_p++;
        slot  = (m_p / (SDIV + 1)) % ND;
        phase = m_p % (SDIV + 1);
        if (phase == 0) begin
            m_dig = 4'hF;
            m_seg = 8'hFF;
        end else begin
            m_dig = ~(4'(1) << slot);
            d     = (prev / pow10(slot)) % 10;
            m_seg = ref_seg(d);
`ifdef LEADING_ZERO_BLANK_EN
            if (slot > 0 && prev < pow10(slot)) m_seg = 8'hFF;
`endif
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare on the falling edge
    task automatic step(input logic r, input logic c, input logic l, input logic [15:0] lv);
        run = r; clr = c; load = l; load_val = lv;
        @(posedge clk);
        model_edge(r, c, l, lv);
        @(negedge clk);
        if (carry_out === 1'b1) carry_seen++;
        chk("model_count", 32'(count_out), 32'(to_bcd(m_cnt)));
        chk("model_carry", 32'(carry_out), 32'(m_carry));
        chk("model_dig_sel", 32'(dig_sel), 32'(m_dig));
        chk("model_seg", 32'(seg_out), 32'(m_seg));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_syn = 1'b0;
        #1;
        chk("rst_count", 32'(count_out), 32'h0);
        chk("rst_carry", 32'(carry_out), 32'h0);
        chk("rst_dig_sel", 32'(dig_sel), 32'hF);
        chk("rst_seg", 32'(seg_out), 32'hFF);
        @(posedge clk);
        @(negedge clk);
        run = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        rst_syn = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        run;
        logic        clr;
        logic        load;
        logic [15:0] lv;
        int          ncyc;
        logic [15:0] exp_count;
        int          exp_carries;
    } vec_t;

    vec_t vecs[10];

    logic [3:0] scan_dig[18];
    logic [7:0] scan_seg[18];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 40, 16'h0010, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h9998,  1, 16'h9998, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0000,  3, 16'h9999, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0000,  4, 16'h0000, 1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h12AF,  1, 16'h1200, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h9999,  1, 16'h9999, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0000,  3, 16'h9999, 0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 16'h1234,  1, 16'h0000, 0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h0000,  4, 16'h0001, 0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 16'h0000,  3, 16'h0001, 0};

        scan_dig = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                     4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
        scan_seg = '{8'hFF, 8'hC0, 8'hF9, 8'hF9, 8'hFF, 8'hA4, 8'hA4, 8'hA4, 8'hFF,
                     8'hB0, 8'hB0, 8'hB0, 8'hFF, 8'h99, 8'h99, 8'h99, 8'hFF, 8'hF9};

        model_reset();

        // Counting, load, wrap/carry and priority vectors
        do_reset();
        for (int i = 0; i < 10; i++) begin
            carry_seen = 0;
            for (int k = 0; k < vecs[i].ncyc; k++)
                step(vecs[i].run, vecs[i].clr, vecs[i].load, vecs[i].lv);
            chk($sformatf("vec%0d_count", i), 32'(count_out), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_carries", i), 32'(carry_seen), 32'(vecs[i].exp_carries));
        end

        // Scan sequence with count held at 4321 (first show slot still decodes the pre-load value)
        do_reset();
        chk("scan0_dig", 32'(dig_sel), 32'(scan_dig[0]));
        chk("scan0_seg", 32'(seg_out), 32'(scan_seg[0]));
        for (int k = 1; k < 18; k++) begin
            step(1'b0, 1'b0, (k == 1), 16'h4321);
            chk($sformatf("scan%0d_dig", k), 32'(dig_sel), 32'(scan_dig[k]));
            if (k >= 2) chk($sformatf("scan%0d_seg", k), 32'(seg_out), 32'(scan_seg[k]));
        end

        // Reset asserted in the middle of a show slot
        do_reset();
        step(1'b0, 1'b0, 1'b1, 16'h0057);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("mid_pre_dig", 32'(dig_sel), 32'hE);
        #2 rst_syn = 1'b0;
        #1;
        chk("mid_rst_dig", 32'(dig_sel), 32'hF);
        chk("mid_rst_seg", 32'(seg_out), 32'hFF);
        chk("mid_rst_count", 32'(count_out), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_syn = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("mid_first_slot_dig", 32'(dig_sel), 32'hE);
        chk("mid_first_slot_seg", 32'(seg_out), 32'hC0);

        // Leading-zero display behaviour with count 0050
        do_reset();
        for (int k = 1; k < 18; k++) begin
            step(1'b0, 1'b0, (k == 1), 16'h0050);
            if (k == 6)  begin chk("lz_d1_dig", 32'(dig_sel), 32'hD); chk("lz_d1_seg", 32'(seg_out), 32'h92); end
            if (k == 17) begin chk("lz_d0_dig", 32'(dig_sel), 32'hE); chk("lz_d0_seg", 32'(seg_out), 32'hC0); end
`ifdef LEADING_ZERO_BLANK_EN
            if (k == 10) begin chk("lz_d2_dig", 32'(dig_sel), 32'hB); chk("lz_d2_seg", 32'(seg_out), 32'hFF); end
            if (k == 14) begin chk("lz_d3_dig", 32'(dig_sel), 32'h7); chk("lz_d3_seg", 32'(seg_out), 32'hFF); end
`else
            if (k == 10) begin chk("lz_d2_dig", 32'(dig_sel), 32'hB); chk("lz_d2_seg", 32'(seg_out), 32'hC0); end
            if (k == 14) begin chk("lz_d3_dig", 32'(dig_sel), 32'h7); chk("lz_d3_seg", 32'(seg_out), 32'hC0); end
`endif
        end

        // Randomized traffic; near-all-nines loads provoke wraps and carries
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic        r, c, l;
            logic [15:0] lv;
            r = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 63) == 0);
            l = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < ND; i++) lv[4*i +: 4] = 4'($urandom_range(7, 9));
            end else begin
                lv = 16'($urandom);
            end
            step(r, c, l, lv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
- Multi-digit BCD counter controller that sequences a cascade of NUM_DIGITS decimal digits.
- Each increment comes from an internal tick divider; carries ripple decimally between digits.
- Time-multiplexes one shared seven-segment decoder across all digits using a blank-then-show scan FSM.
- Sits between board-level switches/buttons and the multiplexed 7-seg display, which shares segment lines and uses per-digit common enables.

Parameters:
- NUM_DIGITS, 4: number of cascaded BCD digits (2..8).
- TICK_DIV, 50000: clocks per count increment while run=1 (>=2).
- SCAN_DIV, 1000: clocks each digit is shown per scan slot (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_syn  in  1  asynchronous, active-low reset.
- run  in  1  enables the tick divider and counting.
- clr  in  1  synchronous clear of the count and the tick divider.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  4*NUM_DIGITS  BCD value to load; digit 0 in bits [3:0].
- count_out  out  4*NUM_DIGITS  current BCD count.
- carry_out  out  1  one-cycle pulse when the count wraps from all-9s to 0.
- seg_out  out  8  active-low segments; bit7 = dp, always 1 (dp off).
- dig_sel  out  NUM_DIGITS  active-low one-cold digit enable.

Behaviour:
- Reset (rst_syn=0, async):
  - count_out=0, carry_out=0, tick counter=0.
  - Scan FSM=BLANK, idx=0, scan counter=0.
  - dig_sel=all 1s, seg_out=8'hFF.
- Tick divider:
  - Counts 0..TICK_DIV-1 only while run=1, then wraps.
  - tick=1 in the cycle the counter equals TICK_DIV-1 and run=1.
  - run=0 holds the counter value.
- Count priority per edge: clr > load > tick.
  - clr: count=0, tick counter=0, carry_out=0.
  - load: each digit takes its load_val nibble; a nibble >9 loads 0. Tick counter is not reset. No carry.
  - tick: digit 0 increments. A digit at 9 becomes 0 and increments the next digit.
  - All digits at 9 on tick: count becomes 0 and carry_out=1 for exactly that one cycle.
- Latency:
  - count_out changes on the same edge that samples clr, load or tick.
  - carry_out is registered and coincides with the wrap to zero.
- Scan FSM, two states:
  - BLANK, 1 cycle: dig_sel=all 1s, seg_out=8'hFF. Next state is SHOW with scan counter=0.
  - SHOW, SCAN_DIV cycles: dig_sel has only bit idx low; seg_out=decode(digit idx) is re-registered every cycle, so a count change shows within 1 cycle.
  - Leaving SHOW: go to BLANK with idx=idx+1, wrapping from NUM_DIGITS-1 to 0.
  - Slot period is SCAN_DIV+1 clocks; a full frame is NUM_DIGITS*(SCAN_DIV+1) clocks.
- Decode, active-low, bit7 = dp:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90.
  - Digits are always valid BCD internally; the decoder default is FF.
- Scan independence: the scan runs regardless of run, clr and load. Only reset restarts it.
- Reset mid-operation: all state returns to reset values immediately; dig_sel is all 1s within the reset assertion.
- Simultaneous clr+load+tick: clr wins and no carry is produced.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, digit idx>0 outputs seg_out=8'hFF when it and all higher digits are 0. dig_sel behaves the same either way. Digit 0 is always displayed.
- Not defined: all digits are always decoded, leading zeros included.

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK=8'hFF;
  - a typedef for a BCD digit (4 bits);
  - the scan state enum {BLANK, SHOW};
  - the ten segment code constants.
- Sub-module seg7_decode: combinational 4-bit BCD to 8-bit active-low segments. One shared instance, fed by the idx mux.
- Counter cascade, dividers and FSM stay in bcd_scan_ctrl.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=3):
- Reset, then run=1 for 40 clocks -> count_out=16'h0010 (one tick per 4 clocks); no carry_out.
- load=1 with load_val=16'h9998, run=1 -> 16'h9999 after 4 clocks; 4 clocks later 16'h0000 with carry_out high for exactly 1 cycle.
- load_val=16'h12AF -> count_out=16'h1200 (invalid nibbles become 0); clr+load+tick in the same cycle -> 0, no carry.
- Count held at 16'h4321, observe 16 clocks after reset:
  - BLANK (FF, dig_sel=F);
  - 3 cycles dig_sel=E with seg F9;
  - BLANK;
  - 3 cycles dig_sel=D with seg A4;
  - then B/B0, 7/99;
  - then wrap to E.
- Assert rst_syn low mid-SHOW while count=16'h0057 -> dig_sel=F, seg_out=FF, count 0 immediately; after release, first slot is digit 0.
- With LEADING_ZERO_BLANK_EN defined, count=16'h0050:
  - slots 3 and 2 show FF with dig_sel 7 and B;
  - slot 1 shows 92;
  - slot 0 shows C0.
